// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the sample FIFO family.
package fifo_pkg;

  // A level or pointer needs one extra bit so that "full" (DEPTH) is representable.
  localparam int unsigned PtrExtraBits = 1;

  localparam int unsigned DefDataSize = 12;
  localparam int unsigned DefAddrSize = 8;

  function automatic int unsigned fifo_depth(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  function automatic int unsigned level_width(input int unsigned addr_size);
    return addr_size + PtrExtraBits;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module sdp_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DefDataSize,
  parameter int unsigned ADDR_SIZE = DefAddrSize
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] waddr_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_SIZE-1:0] raddr_i,
  output logic [DATA_SIZE-1:0] rdata_o
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_SIZE);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [DATA_SIZE-1:0] rdata_q;

  // Storage array: no reset, contents survive reset and flush.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Read register; reset so the FIFO output reads zero out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock sample FIFO with level, almost flags, sticky errors, flush and optional FWFT.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DefDataSize,
  parameter int unsigned ADDR_SIZE = DefAddrSize,
  parameter bit          FWFT      = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 w_inc_i,
  input  logic [DATA_SIZE-1:0] w_data_i,
  output logic                 w_full_o,
  output logic                 w_almost_full_o,
  input  logic                 r_inc_i,
  output logic [DATA_SIZE-1:0] r_data_o,
  output logic                 r_valid_o,
  output logic                 r_empty_o,
  output logic                 r_almost_empty_o,
  input  logic [ADDR_SIZE:0]   af_thresh_i,
  input  logic [ADDR_SIZE:0]   ae_thresh_i,
  output logic [ADDR_SIZE:0]   level_o,
  input  logic                 clr_err_i,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_SIZE);
  localparam int unsigned LW    = level_width(ADDR_SIZE);
  localparam logic [LW-1:0] DepthLvl = LW'(DEPTH);
  localparam logic [LW-1:0] OneLvl   = LW'(1);

  logic [LW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d, ram_count;
  logic                 full, empty, wr_en, rd_en, fetch, ram_re;
  logic                 rd_pend_q, rd_pend_d, rvld_q, rvld_d, fw_vld_q, fw_vld_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  logic [DATA_SIZE-1:0] ram_rdata, dout_q, dout_d;

  assign full      = (level_q == DepthLvl);
  // In FWFT mode only a presented word is readable; words still in RAM are not.
  assign empty     = FWFT ? ~fw_vld_q : (level_q == '0);
  // Words sitting in RAM that have not yet been fetched into the read register.
  assign ram_count = wptr_q - rptr_q;

  // Next-state: access acceptance, pointers, level, output pipeline and errors.
  always_comb begin
    wr_en     = w_inc_i & ~full & ~flush_i;
    rd_en     = r_inc_i & ~empty & ~flush_i;
    // FWFT prefetch: refill the read register whenever it is free or being popped.
    fetch     = FWFT & ~flush_i & (ram_count != '0) & (~fw_vld_q | rd_en);
    ram_re    = FWFT ? fetch : rd_en;

    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    fw_vld_d  = FWFT & (fetch | (fw_vld_q & ~rd_en));
    rd_pend_d = ~FWFT & rd_en;
    rvld_d    = rd_pend_q & ~flush_i;
    dout_d    = (rd_pend_q & ~flush_i) ? ram_rdata : dout_q;

    if (flush_i) begin
      wptr_d   = '0;
      rptr_d   = '0;
      level_d  = '0;
      fw_vld_d = 1'b0;
    end else begin
      if (wr_en) wptr_d = wptr_q + OneLvl;
      if (ram_re) rptr_d = rptr_q + OneLvl;
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + OneLvl;
        2'b01:   level_d = level_q - OneLvl;
        default: level_d = level_q;
      endcase
    end

    // A new error event beats a clear in the same cycle; flushed accesses raise nothing.
    ovf_d = (ovf_q & ~clr_err_i) | (w_inc_i & full & ~flush_i);
    unf_d = (unf_q & ~clr_err_i) | (r_inc_i & empty & ~flush_i);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      fw_vld_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      rvld_q    <= 1'b0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      fw_vld_q  <= fw_vld_d;
      rd_pend_q <= rd_pend_d;
      rvld_q    <= rvld_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  sdp_ram #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (wr_en),
    .waddr_i(wptr_q[ADDR_SIZE-1:0]),
    .wdata_i(w_data_i),
    .re_i   (ram_re),
    .raddr_i(rptr_q[ADDR_SIZE-1:0]),
    .rdata_o(ram_rdata)
  );

  assign r_data_o         = FWFT ? ram_rdata : dout_q;
  assign r_valid_o        = FWFT ? fw_vld_q : rvld_q;
  assign r_empty_o        = empty;
  assign w_full_o         = full;
  assign w_almost_full_o  = (level_q >= af_thresh_i);
  assign r_almost_empty_o = (level_q <= ae_thresh_i);
  assign level_o          = level_q;
  assign overflow_o       = ovf_q;
  assign underflow_o      = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: one standard-read and one FWFT instance share the same stimulus.
module tb_sync_fifo_flags;

  localparam int unsigned DW = 12;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst, flush, w_inc, r_inc, clr_err;
  logic [DW-1:0] w_data;
  logic [AW:0]   af_th, ae_th;

  logic          full0, afull0, valid0, empty0, aempty0, ovf0, unf0;
  logic [DW-1:0] rdata0;
  logic [AW:0]   level0;
  logic          full1, afull1, valid1, empty1, aempty1, ovf1, unf1;
  logic [DW-1:0] rdata1;
  logic [AW:0]   level1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .FWFT(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .w_inc_i(w_inc), .w_data_i(w_data), .w_full_o(full0), .w_almost_full_o(afull0),
    .r_inc_i(r_inc), .r_data_o(rdata0), .r_valid_o(valid0), .r_empty_o(empty0),
    .r_almost_empty_o(aempty0), .af_thresh_i(af_th), .ae_thresh_i(ae_th),
    .level_o(level0), .clr_err_i(clr_err), .overflow_o(ovf0), .underflow_o(unf0)
  );

  sync_fifo_flags #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .FWFT(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .w_inc_i(w_inc), .w_data_i(w_data), .w_full_o(full1), .w_almost_full_o(afull1),
    .r_inc_i(r_inc), .r_data_o(rdata1), .r_valid_o(valid1), .r_empty_o(empty1),
    .r_almost_empty_o(aempty1), .af_thresh_i(af_th), .ae_thresh_i(ae_th),
    .level_o(level1), .clr_err_i(clr_err), .overflow_o(ovf1), .underflow_o(unf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      w_inc  = 1'b1;
      w_data = DW'(base + i);
      step();
    end
    w_inc = 1'b0;
  endtask

  // Back-to-back standard reads: word k shows on r_data one cycle after its read edge.
  task automatic read_burst(input int n, input int base);
    for (int k = 0; k <= n + 1; k++) begin
      r_inc = (k < n);
      step();
      if (k >= 1 && k <= n) begin
        check("rd_valid", 32'(valid0), 32'd1);
        check("rd_data", 32'(rdata0), 32'(base + k - 1));
      end else begin
        check("rd_valid_idle", 32'(valid0), 32'd0);
      end
    end
    r_inc = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; w_inc = 1'b0; r_inc = 1'b0; clr_err = 1'b0;
    w_data = '0; af_th = '0; ae_th = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state (af threshold 0 makes almost-full true at level 0).
    check("rst_level", 32'(level0), 32'd0);
    check("rst_full", 32'(full0), 32'd0);
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_aempty", 32'(aempty0), 32'd1);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_data", 32'(rdata0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    check("rst_unf", 32'(unf0), 32'd0);
    check("rst_afull_th0", 32'(afull0), 32'd1);
    check("rst_fw_empty", 32'(empty1), 32'd1);
    check("rst_fw_data", 32'(rdata1), 32'd0);
    af_th = 4'd8;
    #1;
    check("rst_afull_th8", 32'(afull0), 32'd0);

    // 1. Fill and drain in order.
    w_inc = 1'b1; w_data = 12'h001;
    step();
    check("t1_empty_after_wr", 32'(empty0), 32'd0);
    check("t1_level1", 32'(level0), 32'd1);
    write_burst(7, 2);
    check("t1_full", 32'(full0), 32'd1);
    check("t1_level8", 32'(level0), 32'd8);
    read_burst(8, 1);
    check("t1_empty", 32'(empty0), 32'd1);
    check("t1_level0", 32'(level0), 32'd0);
    check("t1_data_hold", 32'(rdata0), 32'h008);

    // 2. Overflow is sticky and the rejected word never appears.
    write_burst(8, 'h11);
    w_inc = 1'b1; w_data = 12'hFFF;
    step();
    w_inc = 1'b0;
    check("t2_ovf", 32'(ovf0), 32'd1);
    check("t2_level", 32'(level0), 32'd8);
    step();
    check("t2_ovf_sticky", 32'(ovf0), 32'd1);
    read_burst(8, 'h11);
    check("t2_empty", 32'(empty0), 32'd1);
    check("t2_ovf_after_rd", 32'(ovf0), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t2_ovf_clr", 32'(ovf0), 32'd0);

    // 3. Underflow, and set beats clear.
    r_inc = 1'b1;
    step();
    r_inc = 1'b0;
    check("t3_unf", 32'(unf0), 32'd1);
    check("t3_level", 32'(level0), 32'd0);
    check("t3_no_valid", 32'(valid0), 32'd0);
    clr_err = 1'b1; r_inc = 1'b1;
    step();
    r_inc = 1'b0;
    check("t3_unf_set_wins", 32'(unf0), 32'd1);
    step();
    clr_err = 1'b0;
    check("t3_unf_clr", 32'(unf0), 32'd0);

    // 4. Almost flags, then steady simultaneous read/write.
    af_th = 4'd6; ae_th = 4'd2;
    #1;
    check("t4_aempty0", 32'(aempty0), 32'd1);
    check("t4_afull0", 32'(afull0), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      w_inc = 1'b1; w_data = DW'('h20 + i);
      step();
      check("t4_afull", 32'(afull0), 32'(i >= 6));
      check("t4_aempty", 32'(aempty0), 32'(i <= 2));
    end
    for (int k = 0; k < 20; k++) begin
      w_inc = 1'b1; r_inc = 1'b1; w_data = DW'('h27 + k);
      step();
      check("t4_level_const", 32'(level0), 32'd6);
      if (k >= 1) check("t4_rw_data", 32'(rdata0), 32'('h21 + k - 1));
    end
    w_inc = 1'b0; r_inc = 1'b0;
    step();
    check("t4_last_valid", 32'(valid0), 32'd1);
    check("t4_last_data", 32'(rdata0), 32'h034);
    check("t4_level6", 32'(level0), 32'd6);
    read_burst(6, 'h35);
    check("t4_drained", 32'(empty0), 32'd1);

    // 5. FWFT presentation latency and bubble-free pops.
    rst = 1'b1;
    step();
    rst = 1'b0; af_th = 4'd8; ae_th = 4'd0;
    w_inc = 1'b1; w_data = 12'h0A5;
    step();
    w_inc = 1'b0;
    check("t5_empty_edge_n", 32'(empty1), 32'd1);
    step();
    check("t5_empty_edge_n1", 32'(empty1), 32'd0);
    check("t5_data", 32'(rdata1), 32'h0A5);
    check("t5_valid", 32'(valid1), 32'd1);
    write_burst(3, 'hB1);
    check("t5_level4", 32'(level1), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("t5_pop_valid", 32'(valid1), 32'd1);
      check("t5_pop_data", 32'(rdata1), (k == 0) ? 32'h0A5 : 32'('hB1 + k - 1));
      r_inc = 1'b1;
      step();
    end
    r_inc = 1'b0;
    check("t5_empty_end", 32'(empty1), 32'd1);
    check("t5_level_end", 32'(level1), 32'd0);
    check("t5_no_unf", 32'(unf1), 32'd0);

    // 6. Flush with colliding accesses, then wrap the pointers.
    step();
    write_burst(5, 'h31);
    check("t6_level5", 32'(level0), 32'd5);
    check("t6_fw_level5", 32'(level1), 32'd5);
    flush = 1'b1; w_inc = 1'b1; r_inc = 1'b1; w_data = 12'h777;
    step();
    flush = 1'b0; w_inc = 1'b0; r_inc = 1'b0;
    check("t6_level0", 32'(level0), 32'd0);
    check("t6_empty", 32'(empty0), 32'd1);
    check("t6_valid", 32'(valid0), 32'd0);
    check("t6_ovf", 32'(ovf0), 32'd0);
    check("t6_unf", 32'(unf0), 32'd0);
    check("t6_fw_level0", 32'(level1), 32'd0);
    check("t6_fw_empty", 32'(empty1), 32'd1);
    check("t6_fw_unf", 32'(unf1), 32'd0);
    for (int r = 0; r < 4; r++) begin
      write_burst(5, 'h41 + 5 * r);
      read_burst(5, 'h41 + 5 * r);
    end
    check("t6_wrap_empty", 32'(empty0), 32'd1);
    check("t6_fw_wrap_level", 32'(level1), 32'd0);
    check("t6_fw_wrap_unf", 32'(unf1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
